// File: rtl/hit_scheduler_pkg.sv
// Shared types and helpers for the player-hit scheduling logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hit_scheduler_pkg;

    // Upper bound on hazard requesters; sets the width of source indices.
    localparam int MAX_REQ = 8;
    localparam int SRC_W   = $clog2(MAX_REQ);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        HIT      = 2'd2,
        COOLDOWN = 2'd3
    } sched_state_t;

    // Round-robin pointer advance: one past the granted index, wrapping at n.
    function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] cur,
                                                  input int n);
        if (int'(cur) >= n - 1) begin
            return '0;
        end
        return cur + SRC_W'(1);
    endfunction

endpackage

// File: rtl/hit_scheduler_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; valid is low when no request is set.
module rr_pick
    import hit_scheduler_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] sel,
    output logic             valid
);

    int               base_idx;
    int               idx;
    logic [N_REQ-1:0] shifted;

    // Scan every offset from the pointer and keep the first hit.
    always_comb begin
        sel      = '0;
        valid    = 1'b0;
        idx      = 0;
        shifted  = '0;
        // An out-of-range pointer falls back to index 0.
        base_idx = (int'(ptr) < N_REQ) ? int'(ptr) : 0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = base_idx + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            shifted = req >> idx;
            if (!valid && shifted[0]) begin
                valid = 1'b1;
                sel   = SRC_W'(idx);
            end
        end
    end

endmodule

// File: rtl/hit_scheduler.sv
// Grants hazard collision requests round-robin, pulses player_hit, then runs an i-frame window.
// Latency: request to player_hit/hit_ack is 1 cycle; all outputs registered.
// Backpressure: none; requests are levels, those arriving outside ARMED are simply not served.
module hit_scheduler
    import hit_scheduler_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int IFRAME_FRAMES = 60,
    parameter int BLINK_BIT     = 3
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             game_on,
    input  logic             game_over,
    input  logic             vsync_in,
    input  logic [N_REQ-1:0] hit_req,
    output logic [N_REQ-1:0] hit_ack,
    output logic             player_hit,
    output logic             invuln,
    output logic             blink,
    output logic [2:0]       last_src
);

    // Frame count value on which the final cooldown tick lands.
    localparam logic [7:0] LAST_FRAME = 8'((IFRAME_FRAMES == 0) ? 0 : IFRAME_FRAMES - 1);

    sched_state_t     state;
    sched_state_t     state_nx;
    logic [7:0]       frame_cnt;
    logic [7:0]       frame_cnt_nx;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] rr_ptr_nx;
    logic             vsync_q;
    logic             frame_tick;
    logic             abort;

    logic [N_REQ-1:0] ack_nx;
    logic             hit_nx;
    logic             invuln_nx;
    logic             blink_nx;
    logic [2:0]       last_src_nx;

    logic [SRC_W-1:0] pick_sel;
    logic             pick_vld;

    assign frame_tick = vsync_in & ~vsync_q;
    assign abort      = ~game_on | game_over;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (hit_req),
        .ptr   (rr_ptr),
        .sel   (pick_sel),
        .valid (pick_vld)
    );

    // Next-state, counter and registered-output values; abort overrides everything.
    always_comb begin
        state_nx     = state;
        frame_cnt_nx = frame_cnt;
        rr_ptr_nx    = rr_ptr;
        ack_nx       = '0;
        hit_nx       = 1'b0;
        invuln_nx    = invuln;
        last_src_nx  = last_src;

        if (abort) begin
            state_nx     = IDLE;
            frame_cnt_nx = '0;
            invuln_nx    = 1'b0;
            last_src_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx  = ARMED;
                    invuln_nx = 1'b0;
                end
                ARMED: begin
                    invuln_nx = 1'b0;
                    if (pick_vld) begin
                        state_nx    = HIT;
                        hit_nx      = 1'b1;
                        last_src_nx = pick_sel;
                        rr_ptr_nx   = next_ptr(pick_sel, N_REQ);
                        for (int i = 0; i < N_REQ; i++) begin
                            ack_nx[i] = (int'(pick_sel) == i);
                        end
                    end
                end
                HIT: begin
                    frame_cnt_nx = '0;
                    if (IFRAME_FRAMES == 0) begin
                        state_nx  = ARMED;
                        invuln_nx = 1'b0;
                    end else begin
                        state_nx  = COOLDOWN;
                        invuln_nx = 1'b1;
                    end
                end
                COOLDOWN: begin
                    invuln_nx = 1'b1;
                    if (frame_tick) begin
                        frame_cnt_nx = frame_cnt + 8'd1;
                        if (frame_cnt == LAST_FRAME) begin
                            state_nx  = ARMED;
                            invuln_nx = 1'b0;
                        end
                    end
                end
                default: begin
                    state_nx  = IDLE;
                    invuln_nx = 1'b0;
                end
            endcase
        end

        // Blink follows the registered counter so it lines up with invuln.
        blink_nx = invuln_nx & frame_cnt_nx[BLINK_BIT];
    end

    // State, frame counter, arbitration pointer and vsync edge history.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            frame_cnt <= '0;
            rr_ptr    <= '0;
            vsync_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            frame_cnt <= frame_cnt_nx;
            rr_ptr    <= rr_ptr_nx;
            vsync_q   <= vsync_in;
        end
    end

    // Registered outputs toward the HP controller and sprite renderer.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hit_ack    <= '0;
            player_hit <= 1'b0;
            invuln     <= 1'b0;
            blink      <= 1'b0;
            last_src   <= '0;
        end else begin
            hit_ack    <= ack_nx;
            player_hit <= hit_nx;
            invuln     <= invuln_nx;
            blink      <= blink_nx;
            last_src   <= last_src_nx;
        end
    end

endmodule
